// File: rtl/srl2prl_fifo.sv
// rtl/srl2prl_fifo.sv - serial-to-parallel byte assembler feeding a first-word fall-through FIFO
// Bits arrive MSB first; a partial byte is abandoned after TIMEOUT idle cycles mid-byte.
module srl2prl_fifo #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     srl_in,
    input  logic                     srl_valid,
    output logic [7:0]               prl_out,
    output logic                     prl_valid,
    input  logic                     prl_ready,
    output logic                     frame_err,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      sreg_q, sreg_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            frame_err_q, frame_err_d;
    logic            overflow_q, overflow_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      mem_q [DEPTH];

    logic            byte_done;
    logic [7:0]      byte_data;
    logic            pop;
    logic            full;
    logic            wr_en;

    assign byte_data = {sreg_q[6:0], srl_in};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sreg_d      = sreg_q;
        gap_d       = gap_q;
        frame_err_d = 1'b0;
        byte_done   = 1'b0;
        case (state_q)
            IDLE: begin
                gap_d = '0;
                if (srl_valid) begin
                    sreg_d    = byte_data;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (srl_valid) begin
                    sreg_d    = byte_data;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    gap_d     = '0;
                    if (bit_cnt_q == 3'd7) begin
                        byte_done = 1'b1;
                        state_d   = IDLE;
                    end
                end else if (gap_q == GW'(TIMEOUT - 1)) begin
                    // This idle cycle is the TIMEOUT-th in a row: abandon the partial byte.
                    sreg_d      = '0;
                    bit_cnt_d   = '0;
                    gap_d       = '0;
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign prl_valid = (level_q != '0);
    assign prl_out   = prl_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign pop       = prl_valid && prl_ready;
    assign full      = (level_q == LW'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign wr_en     = byte_done && (!full || pop);

    always_comb begin
        overflow_d = byte_done && full && !pop;
        wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q;
        if (wr_en && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !wr_en) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            sreg_q      <= '0;
            gap_q       <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sreg_q      <= sreg_d;
            gap_q       <= gap_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= byte_data;
        end
    end

    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
    assign level     = level_q;

endmodule

// File: tb/tb_srl2prl_fifo.sv
// tb/tb_srl2prl_fifo.sv - directed self-checking bench for srl2prl_fifo
module tb_srl2prl_fifo;

    logic       clock = 1'b0;
    logic       rst = 1'b0;
    logic       srl_in = 1'b0;
    logic       srl_valid = 1'b0;
    logic [7:0] prl_out;
    logic       prl_valid;
    logic       prl_ready = 1'b0;
    logic       frame_err;
    logic       overflow;
    logic [2:0] level;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    srl2prl_fifo #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clock(clock), .rst(rst), .srl_in(srl_in), .srl_valid(srl_valid),
        .prl_out(prl_out), .prl_valid(prl_valid), .prl_ready(prl_ready),
        .frame_err(frame_err), .overflow(overflow), .level(level)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (frame_err) fe_cnt++;
        if (overflow) ov_cnt++;
    end

    task automatic send_bit(input logic b);
        srl_in = b;
        srl_valid = 1'b1;
        @(posedge clock);
        #1;
        srl_valid = 1'b0;
        srl_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (i > 0) idle(gap);
        end
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic pop_one();
        prl_ready = 1'b1;
        @(posedge clock);
        #1;
        prl_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (prl_valid !== 1'b0 || prl_out !== 8'h00 || level !== 3'd0 ||
            frame_err !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b out=%h level=%0d fe=%b ov=%b, want 0 00 0 0 0",
                     prl_valid, prl_out, level, frame_err, overflow);
        end
        rst = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_contiguous();
        logic [7:0] b;
        b = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (i == 1) begin
                checks++;
                if (prl_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL a5_not_early: valid=%b want 0", prl_valid);
                end
            end
        end
        checks++;
        if (prl_out !== 8'hA5 || prl_valid !== 1'b1 || level !== 3'd1) begin
            errors++;
            $display("FAIL a5_byte: out=%h valid=%b level=%0d, want a5 1 1", prl_out, prl_valid, level);
        end
        pop_one();
        checks++;
        if (prl_valid !== 1'b0 || prl_out !== 8'h00 || level !== 3'd0) begin
            errors++;
            $display("FAIL a5_pop: out=%h valid=%b level=%0d, want 00 0 0", prl_out, prl_valid, level);
        end
    endtask

    task automatic test_gaps();
        int fe0;
        fe0 = fe_cnt;
        send_byte(8'h3C, 3);
        checks++;
        if (prl_out !== 8'h3C || level !== 3'd1 || fe_cnt != fe0) begin
            errors++;
            $display("FAIL gap3: out=%h level=%0d frame_errs=%0d, want 3c 1 0", prl_out, level, fe_cnt - fe0);
        end
        pop_one();
        send_byte(8'h96, 15);
        checks++;
        if (prl_out !== 8'h96 || level !== 3'd1 || fe_cnt != fe0) begin
            errors++;
            $display("FAIL gap15: out=%h level=%0d frame_errs=%0d, want 96 1 0", prl_out, level, fe_cnt - fe0);
        end
        pop_one();
    endtask

    task automatic test_timeout();
        int fe0;
        fe0 = fe_cnt;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        idle(15);
        checks++;
        if (frame_err !== 1'b0 || fe_cnt != fe0) begin
            errors++;
            $display("FAIL timeout_early: fe=%b count=%0d, want 0 0", frame_err, fe_cnt - fe0);
        end
        idle(1);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse: fe=%b want 1", frame_err);
        end
        send_byte(8'hF0, 0);
        checks++;
        if (prl_out !== 8'hF0 || level !== 3'd1 || fe_cnt != fe0 + 1) begin
            errors++;
            $display("FAIL timeout_f0: out=%h level=%0d frame_errs=%0d, want f0 1 1", prl_out, level, fe_cnt - fe0);
        end
        pop_one();
    endtask

    task automatic test_overflow();
        int ov0;
        logic [7:0] exp;
        ov0 = ov_cnt;
        for (int k = 1; k <= 4; k++) send_byte(8'(k), 0);
        checks++;
        if (level !== 3'd4 || ov_cnt != ov0) begin
            errors++;
            $display("FAIL ovf_fill: level=%0d overflows=%0d, want 4 0", level, ov_cnt - ov0);
        end
        send_byte(8'h05, 0);
        checks++;
        if (level !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_pulse: level=%0d ov=%b, want 4 1", level, overflow);
        end
        idle(2);
        checks++;
        if (ov_cnt != ov0 + 1) begin
            errors++;
            $display("FAIL ovf_count: overflows=%0d want 1", ov_cnt - ov0);
        end
        for (int k = 1; k <= 4; k++) begin
            exp = 8'(k);
            checks++;
            if (prl_valid !== 1'b1 || prl_out !== exp) begin
                errors++;
                $display("FAIL ovf_drain%0d: out=%h valid=%b, want %h 1", k, prl_out, prl_valid, exp);
            end
            pop_one();
        end
        checks++;
        if (level !== 3'd0 || prl_valid !== 1'b0 || prl_out !== 8'h00) begin
            errors++;
            $display("FAIL ovf_empty: level=%0d valid=%b out=%h, want 0 0 00", level, prl_valid, prl_out);
        end
    endtask

    task automatic test_full_write_pop();
        int ov0;
        logic [7:0] b;
        logic [7:0] exp [4];
        exp[0] = 8'h11; exp[1] = 8'h12; exp[2] = 8'h13; exp[3] = 8'h77;
        ov0 = ov_cnt;
        for (int k = 0; k < 4; k++) send_byte(8'h10 + 8'(k), 0);
        b = 8'h77;
        for (int i = 7; i >= 1; i--) send_bit(b[i]);
        prl_ready = 1'b1;
        send_bit(b[0]);
        prl_ready = 1'b0;
        checks++;
        if (level !== 3'd4 || overflow !== 1'b0 || prl_out !== 8'h11) begin
            errors++;
            $display("FAIL full_wp: level=%0d ov=%b head=%h, want 4 0 11", level, overflow, prl_out);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (prl_valid !== 1'b1 || prl_out !== exp[k]) begin
                errors++;
                $display("FAIL full_wp_drain%0d: out=%h valid=%b, want %h 1", k, prl_out, prl_valid, exp[k]);
            end
            pop_one();
        end
        checks++;
        if (ov_cnt != ov0 || level !== 3'd0) begin
            errors++;
            $display("FAIL full_wp_end: overflows=%0d level=%0d, want 0 0", ov_cnt - ov0, level);
        end
    endtask

    task automatic test_empty_write_pop();
        logic [7:0] b;
        b = 8'h5A;
        for (int i = 7; i >= 1; i--) send_bit(b[i]);
        prl_ready = 1'b1;
        send_bit(b[0]);
        prl_ready = 1'b0;
        checks++;
        if (level !== 3'd1 || prl_out !== 8'h5A || prl_valid !== 1'b1) begin
            errors++;
            $display("FAIL empty_wp: level=%0d out=%h valid=%b, want 1 5a 1", level, prl_out, prl_valid);
        end
        pop_one();
    endtask

    task automatic test_async_reset();
        send_byte(8'h21, 0);
        send_byte(8'h22, 0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (prl_valid !== 1'b0 || prl_out !== 8'h00 || level !== 3'd0 ||
            frame_err !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b out=%h level=%0d fe=%b ov=%b, want 0 00 0 0 0",
                     prl_valid, prl_out, level, frame_err, overflow);
        end
        #1;
        rst = 1'b1;
        send_byte(8'hC3, 0);
        checks++;
        if (prl_out !== 8'hC3 || level !== 3'd1 || prl_valid !== 1'b1) begin
            errors++;
            $display("FAIL after_reset: out=%h level=%0d valid=%b, want c3 1 1", prl_out, level, prl_valid);
        end
    endtask

    initial begin
        test_reset();
        test_contiguous();
        test_gaps();
        test_timeout();
        test_overflow();
        do_reset();
        test_full_write_pop();
        test_empty_write_pop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
